uart_rx_word: RTL and testbench

- Receives a serial UART stream on one line and assembles each pair of bytes into a 16-bit word.
- Format per byte: 8N1, LSB-first on the wire.
- It is the receive-side counterpart of our 16-bit UART transmitter. It brings host-supplied samples and coefficients into the FIR datapath, and it closes the TX→RX loopback used in board bring-up.
- Each completed word produces a registered output and a one-cycle valid strobe.

---
 rtl/uart_rx_word.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_word.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_word
// Description : 8N1 UART receiver that pairs consecutive bytes into a 16-bit
//               word. The first good byte is held. The next good byte completes
//               the word, updates data_out and pulses data_valid for one cycle.
//               A low stop bit pulses frame_err and discards everything
//               received so far. A held byte that waits too long for its
//               partner is dropped silently.
// Ports       : clk        - system clock
//               rst        - synchronous, active-high reset
//               rx         - asynchronous serial line, idles high
//               data_out   - last completed word, held between words
//               data_valid - one-cycle pulse when data_out updates
//               frame_err  - one-cycle pulse when a stop bit is sampled low
//               busy       - receiver is mid-frame or holding a first byte
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_word #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int BAUD_TICK    = CLK_FREQ / BAUD_RATE,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int c_BAUD_W    = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
    localparam int c_TO_CYCLES = TIMEOUT_BITS * BAUD_TICK;
    localparam int c_TO_W      = $clog2(c_TO_CYCLES + 1);

    localparam logic [c_BAUD_W-1:0] c_TICK_LAST = c_BAUD_W'(BAUD_TICK - 1);
    // Preload so the counter reaches its last value BAUD_TICK/2 cycles after
    // the start edge, i.e. the first check lands mid start bit.
    localparam logic [c_BAUD_W-1:0] c_HALF_LOAD = c_BAUD_W'(BAUD_TICK - BAUD_TICK / 2);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(c_TO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_rxs;
    logic                r_rxs_prev;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_held;
    logic [7:0]          r_first;
    logic [c_TO_W-1:0]   r_to_cnt;

    logic w_tick;
    logic w_start_edge;

    assign w_tick       = (r_baud_cnt == c_TICK_LAST);
    assign w_start_edge = !r_rxs && r_rxs_prev;
    assign busy         = (r_state != S_IDLE) || r_held;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_held     <= 1'b0;
            r_first    <= '0;
            r_to_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_sync1    <= rx;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // A start edge takes priority over timeout expiry, so a
                    // byte arriving on the expiry cycle still pairs.
                    if (w_start_edge) begin
                        r_state    <= S_START;
                        r_baud_cnt <= c_HALF_LOAD;
                    end else if (r_held) begin
                        if (r_to_cnt == c_TO_LAST) begin
                            r_held   <= 1'b0;
                            r_to_cnt <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_W'(1);
                        end
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        r_baud_cnt <= '0;
                        if (!r_rxs) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            // Line went back high: treat as noise.
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        r_baud_cnt         <= '0;
                        r_shift[r_bit_idx] <= r_rxs;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_tick) begin
                        r_baud_cnt <= '0;
                        if (r_rxs) begin
                            r_state <= S_IDLE;
                            if (!r_held) begin
                                r_first  <= r_shift;
                                r_held   <= 1'b1;
                                r_to_cnt <= '0;
                            end else begin
                                data_out   <= MSB_FIRST ? {r_first, r_shift} : {r_shift, r_first};
                                data_valid <= 1'b1;
                                r_held     <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            r_held    <= 1'b0;
                            r_state   <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
                    end
                end

                S_WAIT_HIGH: begin
                    // Sit out a break or stuck-low line before hunting again.
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_word
// Description : Self-checking bench for uart_rx_word. Two instances share one
//               serial line, one per byte order. A frame-level reference model
//               tracks the held byte, word pairing, timeout drops and frame
//               errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word;

    localparam int c_CLK_FREQ  = 3_200_000;
    localparam int c_BAUD_RATE = 100_000;
    localparam int c_BT        = c_CLK_FREQ / c_BAUD_RATE;
    localparam int c_TO_BITS   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] dout_m, dout_l;
    logic        dv_m, dv_l, fe_m, fe_l, busy_m, busy_l;

    uart_rx_word #(
        .CLK_FREQ(c_CLK_FREQ), .BAUD_RATE(c_BAUD_RATE),
        .MSB_FIRST(1'b1), .TIMEOUT_BITS(c_TO_BITS)
    ) u_dut_msb (
        .clk(clk), .rst(rst), .rx(rx), .data_out(dout_m),
        .data_valid(dv_m), .frame_err(fe_m), .busy(busy_m)
    );

    uart_rx_word #(
        .CLK_FREQ(c_CLK_FREQ), .BAUD_RATE(c_BAUD_RATE),
        .MSB_FIRST(1'b0), .TIMEOUT_BITS(c_TO_BITS)
    ) u_dut_lsb (
        .clk(clk), .rst(rst), .rx(rx), .data_out(dout_l),
        .data_valid(dv_l), .frame_err(fe_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled shortly after each rising edge.
    int          vcnt_m = 0, vcnt_l = 0, ecnt_m = 0, ecnt_l = 0;
    int          excl_viol = 0, hold_viol = 0;
    logic [15:0] prev_m = '0, prev_l = '0;
    bit          mon_skip = 1'b0;

    always @(posedge clk) begin
        #2;
        if (dv_m) vcnt_m++;
        if (dv_l) vcnt_l++;
        if (fe_m) ecnt_m++;
        if (fe_l) ecnt_l++;
        if ((dv_m && fe_m) || (dv_l && fe_l)) excl_viol++;
        if (!mon_skip && ((!dv_m && dout_m != prev_m) || (!dv_l && dout_l != prev_l)))
            hold_viol++;
        prev_m = dout_m;
        prev_l = dout_l;
    end

    // Frame-level reference model.
    bit          m_held   = 1'b0;
    logic [7:0]  m_first  = '0;
    int          m_vcnt   = 0;
    int          m_ecnt   = 0;
    logic [15:0] m_word_m = '0;
    logic [15:0] m_word_l = '0;

    task automatic drive_bits(input logic v, input int nbits);
        rx = v;
        repeat (nbits * c_BT) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_vcnt_m"}, vcnt_m, m_vcnt);
        check({tag, "_vcnt_l"}, vcnt_l, m_vcnt);
        check({tag, "_ecnt_m"}, ecnt_m, m_ecnt);
        check({tag, "_ecnt_l"}, ecnt_l, m_ecnt);
        check({tag, "_dout_m"}, dout_m, m_word_m);
        check({tag, "_dout_l"}, dout_l, m_word_l);
        check({tag, "_busy_m"}, busy_m, m_held);
        check({tag, "_busy_l"}, busy_l, m_held);
    endtask

    // idle_before: whole idle bits ahead of the start bit.
    // low_after  : extra bit periods the line stays low after a bad stop bit.
    task automatic send_frame(input string tag, input logic [7:0] d, input bit stop_ok,
                              input int idle_before, input int low_after);
        drive_bits(1'b1, idle_before);
        // The gap from mid stop bit to the next start edge is idle+0.5 bits.
        if (m_held && idle_before >= c_TO_BITS) m_held = 1'b0;
        drive_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bits(d[i], 1);
        if (stop_ok) begin
            drive_bits(1'b1, 1);
            if (m_held) begin
                m_word_m = {m_first, d};
                m_word_l = {d, m_first};
                m_vcnt++;
                m_held = 1'b0;
            end else begin
                m_first = d;
                m_held  = 1'b1;
            end
        end else begin
            rx = 1'b0;
            repeat (c_BT + (low_after * c_BT) / 2) @(negedge clk);
            check({tag, "_busylow_m"}, busy_m, 1);
            check({tag, "_busylow_l"}, busy_l, 1);
            repeat (low_after * c_BT - (low_after * c_BT) / 2) @(negedge clk);
            drive_bits(1'b1, 1);
            m_ecnt++;
            m_held = 1'b0;
        end
        check_state(tag);
    endtask

    initial begin
        logic [7:0] rd;
        int         r, idle, low;
        bit         ok;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_dout_m", dout_m, 0);
        check("rst_dout_l", dout_l, 0);
        check("rst_dv_m", dv_m, 0);
        check("rst_dv_l", dv_l, 0);
        check("rst_fe_m", fe_m, 0);
        check("rst_fe_l", fe_l, 0);
        check("rst_busy_m", busy_m, 0);
        check("rst_busy_l", busy_l, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic pair, one idle bit between frames
        send_frame("p12", 8'h12, 1'b1, 2, 0);
        send_frame("p34", 8'h34, 1'b1, 1, 0);

        // Back-to-back frames with no idle bits
        send_frame("pAB", 8'hAB, 1'b1, 1, 0);
        send_frame("pCD", 8'hCD, 1'b1, 0, 0);

        // Short low glitch: false start, nothing received
        drive_bits(1'b1, 2);
        rx = 1'b0;
        repeat (c_BT / 2 - 6) @(negedge clk);
        drive_bits(1'b1, 3);
        check_state("glitch");
        send_frame("p00", 8'h00, 1'b1, 1, 0);
        send_frame("pFF", 8'hFF, 1'b1, 0, 0);

        // Bad stop bit with the line held low, then a clean pair
        send_frame("ferr", 8'h55, 1'b0, 1, 4);
        send_frame("fe12", 8'h12, 1'b1, 1, 0);
        send_frame("fe34", 8'h34, 1'b1, 0, 0);

        // Held byte timeout: dropped after a long gap, kept after a shorter one
        send_frame("to77a", 8'h77, 1'b1, 1, 0);
        send_frame("to12a", 8'h12, 1'b1, c_TO_BITS + 1, 0);
        send_frame("to34a", 8'h34, 1'b1, 0, 0);
        send_frame("to77b", 8'h77, 1'b1, 1, 0);
        send_frame("to12b", 8'h12, 1'b1, c_TO_BITS - 1, 0);

        // 0x34 is now held; reset mid-way through the next byte's data bits
        send_frame("hold34", 8'h34, 1'b1, 1, 0);
        drive_bits(1'b1, 2);
        drive_bits(1'b0, 1);
        rd = 8'hC3;
        for (int i = 0; i < 4; i++) drive_bits(rd[i], 1);
        mon_skip = 1'b1;
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_dout_m", dout_m, 0);
        check("mrst_dout_l", dout_l, 0);
        check("mrst_dv_m", dv_m, 0);
        check("mrst_fe_m", fe_m, 0);
        check("mrst_busy_m", busy_m, 0);
        check("mrst_busy_l", busy_l, 0);
        m_held   = 1'b0;
        m_word_m = '0;
        m_word_l = '0;
        repeat (4) @(negedge clk);
        mon_skip = 1'b0;
        send_frame("rs12", 8'h12, 1'b1, 3, 0);
        send_frame("rs34", 8'h34, 1'b1, 1, 0);

        // Randomized frames: data, gaps, occasional bad stop bits
        for (int k = 0; k < 40; k++) begin
            rd = 8'($urandom_range(0, 255));
            r  = $urandom_range(0, 9);
            if (r < 6)      idle = r % 3;
            else if (r < 8) idle = c_TO_BITS - 1;
            else            idle = c_TO_BITS + 1 + r;
            ok  = ($urandom_range(0, 7) != 0);
            low = $urandom_range(0, 3);
            send_frame("rnd", rd, ok, idle, low);
        end

        drive_bits(1'b1, 2);
        check("dv_fe_exclusive", excl_viol, 0);
        check("dout_hold", hold_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
